rr_ring_arbiter: RTL
====================

Name: rr_ring_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters.
- Rotating priority is held in a one-hot ring pointer that advances one position past each granted owner.
- Sits in front of any shared sequential resource (counter, shift register, bus port) and drives its one-hot select.
- Registered grant with direct owner-to-owner handoff and optional hold-time preemption.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; used only with the optional feature; legal minimum 2.
- IDW, $clog2(N), width of gnt_id (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; requester i holds req[i] high for as long as it needs the resource.
- gnt  out  N  one-hot grant (all-zero when idle); registered.
- gnt_id  out  IDW  binary index of the current owner; 0 when idle.
- busy  out  1  high while any grant is active.
- preempt  out  1  one-cycle pulse when a grant is revoked by timeout (optional feature only).

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE, ptr=one-hot bit0, gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0.
  - Reset mid-grant drops gnt immediately, with no release handshake.
- pick(req, ptr): first set bit of req scanning circularly upward from ptr's position. Pure combinational; result is one-hot or zero.
- IDLE:
  - If |req, then next edge: gnt<=pick(req,ptr), gnt_id<=index, busy<=1, state->BUSY.
  - Request-to-grant latency is 1 cycle.
- BUSY, owner still requesting (req&gnt != 0): gnt held unchanged, ptr unchanged.
- BUSY, owner releases (req&gnt == 0):
  - ptr<=rotl(gnt), i.e. one past the owner.
  - If other requests exist, gnt<=pick(req, rotl(gnt)) on the same edge (zero-bubble handoff); state stays BUSY.
  - Else gnt<=0, busy<=0, state->IDLE.
- Fairness: with all N requesting continuously and releasing after k cycles each, grants visit i, i+1, ..., wrap to 0; no requester waits more than N-1 tenures.
- Wrap-around: rotl of bit N-1 gives bit0.
- Simultaneous release and new request by the same requester in one cycle: treated as a release. The requester re-competes at the lowest priority.
- Requester dropping req before being granted: no effect; never granted.
- Invariants: gnt is always one-hot or zero; gnt_id always matches gnt; busy == |gnt.

Optional Feature:
- Macro: RR_RING_ARBITER_TIMEOUT_EN.
- Defined:
  - hold_cnt counts BUSY cycles for the current owner and resets to 0 on every grant change.
  - When hold_cnt == MAX_HOLD-1 and the owner still requests, the owner is revoked on the next edge: ptr<=rotl(gnt), gnt<=pick(req & ~gnt, rotl(gnt)), preempt<=1 for one cycle.
  - If no other requester exists, the owner keeps the grant, hold_cnt restarts at 0, and preempt stays 0.
- Undefined: no hold_cnt logic; preempt tied 0; grant held indefinitely while the owner requests.

Decomposition:
- Shared package rr_ring_arbiter_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Rotate-left helper function.
  - One-hot-to-index function.
- Sub-module ring_priority_pick (N parameter; inputs req and ptr; output one-hot pick).
  - Implemented as the double-width masked priority encoder.
  - Reused for both the grant and handoff paths.

Test Plan (N=4, MAX_HOLD=8):
- Reset then req=4'b0100 -> one cycle later gnt=0100, gnt_id=2, busy=1; drop req -> next cycle gnt=0, busy=0, ptr=1000.
- req=4'b1111 held, each owner drops req for 1 cycle after 3 cycles -> grant order 0,1,2,3,0 with zero idle cycles between tenures.
- Owner=3, releases while req=4'b0011 -> gnt=0001 on the same edge (wrap), ptr=0001.
- Reset_n asserted low mid-grant (gnt=0010) -> gnt=0, busy=0 asynchronously; after release with req=1111 -> gnt=0001.
- TIMEOUT_EN, req=4'b0011 held continuously -> owner 0 for 8 cycles, preempt pulse, gnt=0010 for 8 cycles, preempt, gnt=0001.
- TIMEOUT_EN, only req[2] held for 20 cycles -> gnt=0100 throughout, preempt never asserted.

Source files
------------

// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the rr_ring_arbiter slice: state encoding,
// ring rotation and one-hot decode, sized for up to MAX_N requesters.
package rr_ring_arbiter_pkg;

    localparam int unsigned MAX_N = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Rotate the low n bits of v left by one; bits at and above n are cleared.
    function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] v,
                                              input int unsigned     n);
        logic [MAX_N-1:0] mask;
        mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_priority_pick.sv
// Circular priority pick: first set bit of req at or above the one-hot ptr,
// wrapping to bit 0. Result is one-hot, or zero when req is empty.
module ring_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] pick
);

    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] ptr_ext;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] lowest;

    // Doubling req lets the lowest set bit at/above ptr in the upper copy
    // stand in for the wrapped search; folding both halves yields one bit.
    always_comb begin
        dbl_req = {req, req};
        ptr_ext = {{N{1'b0}}, ptr};
        masked  = dbl_req & ~(ptr_ext - ONE);
        lowest  = masked & (~masked + ONE);
        pick    = lowest[N-1:0] | lowest[2*N-1:N];
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin ring arbiter with registered one-hot grant and zero-bubble handoff.
// Define RR_RING_ARBITER_TIMEOUT_EN to revoke owners after MAX_HOLD cycles.
module rr_ring_arbiter
    import rr_ring_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("rr_ring_arbiter: N must be 2..16 and MAX_HOLD >= 2");
    end

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   gnt_rot;
    logic [N-1:0]   pick_req, pick_ptr, pick_gnt;
    logic           owner_req;

    // One picker serves both paths: in BUSY the owner is masked out, which is
    // a no-op on release and excludes it on preemption.
    always_comb begin
        gnt_rot   = N'(rotl(MAX_N'(gnt_q), N));
        owner_req = |(req & gnt_q);
        if (state_q == ST_IDLE) begin
            pick_req = req;
            pick_ptr = ptr_q;
        end else begin
            pick_req = req & ~gnt_q;
            pick_ptr = gnt_rot;
        end
    end

    ring_priority_pick #(.N(N)) u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick_gnt)
    );

`ifdef RR_RING_ARBITER_TIMEOUT_EN
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HCW-1:0] hold_q, hold_d;
    logic           preempt_q, preempt_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_BUSY;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    ptr_d = gnt_rot;
                    gnt_d = pick_gnt;
                    if (pick_gnt == '0) state_d = ST_IDLE;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                    hold_d = '0;
`endif
                end else begin
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                    if (hold_q == HCW'(MAX_HOLD - 1)) begin
                        hold_d = '0;
                        if (|pick_gnt) begin
                            ptr_d     = gnt_rot;
                            gnt_d     = pick_gnt;
                            preempt_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        gnt_id_d = IDW'(onehot_to_idx(MAX_N'(gnt_d)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= {{(N-1){1'b0}}, 1'b1};
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef RR_RING_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == ST_BUSY);

endmodule
